cache_write_buffer: RTL

CACHE_WRITE_BUFFER -- requirements
Module: cache_write_buffer

---
 rtl/cache_write_buffer.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/cache_write_buffer.sv
// Write-through store buffer between a cache controller and main memory.
// Buffered stores always drain before a pending refill read is issued.
module cache_write_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       wr_valid,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    output logic                       wr_ready,
    input  logic                       rd_req,
    input  logic [ADDR_W-1:0]          rd_addr,
    output logic [DATA_W-1:0]          rd_data,
    output logic                       rd_done,
    output logic                       mem_req,
    output logic                       mem_we,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [DATA_W-1:0]          mem_wdata,
    input  logic [DATA_W-1:0]          mem_rdata,
    input  logic                       mem_ack,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        READ,
        DONE
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_buf_q [DEPTH];
    logic [ADDR_W-1:0]   addr_buf_d [DEPTH];
    logic [DATA_W-1:0]   data_buf_q [DEPTH];
    logic [DATA_W-1:0]   data_buf_d [DEPTH];
    logic [PTR_W-1:0]    head_q, head_d;
    logic [PTR_W-1:0]    tail_q, tail_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;

    logic push;
    logic pop;

    // wr_ready looks only at the registered count, so a same-cycle pop never frees a slot.
    assign wr_ready = (count_q < DEPTH_CNT);
    assign push     = wr_valid && wr_ready;
    assign pop      = (state_q == WRITE) && mem_ack;
    assign count    = count_q;
    assign rd_data  = rd_data_q;

    always_comb begin
        addr_buf_d = addr_buf_q;
        data_buf_d = data_buf_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;

        if (push) begin
            addr_buf_d[tail_q] = wr_addr;
            data_buf_d[tail_q] = wr_data;
            tail_d             = tail_q + PTR_W'(1);
        end

        if (pop) begin
            head_d = head_q + PTR_W'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        rd_addr_d = rd_addr_q;
        rd_data_d = rd_data_q;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        rd_done   = 1'b0;

        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    state_d = WRITE;
                end else if (rd_req) begin
                    state_d   = READ;
                    rd_addr_d = rd_addr;
                end
            end
            WRITE: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = addr_buf_q[head_q];
                mem_wdata = data_buf_q[head_q];
                if (mem_ack) begin
                    state_d = IDLE;
                end
            end
            READ: begin
                mem_req  = 1'b1;
                mem_addr = rd_addr_q;
                if (mem_ack) begin
                    rd_data_d = mem_rdata;
                    state_d   = DONE;
                end
            end
            DONE: begin
                rd_done = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            rd_addr_q <= '0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            rd_addr_q <= rd_addr_d;
            rd_data_q <= rd_data_d;
        end
    end

    // Entry storage needs no reset: an empty FIFO never exposes its contents.
    always_ff @(posedge CLK) begin
        addr_buf_q <= addr_buf_d;
        data_buf_q <= data_buf_d;
    end

endmodule
